// File: rtl/mdpt_assoc.sv
// Set-associative memory dependence prediction table: ASID-tagged ways, tree-PLRU
// replacement, 1-cycle fetch-block reads, single-lane commit updates, decay and flush.

module mdpt_assoc_lane #(
  parameter int MDP_W   = 8,
  parameter int LANE_W  = 3,
  parameter int LANE_ID = 0
) (
  input  logic [MDP_W-1:0]  old_i,
  input  logic [LANE_W-1:0] sel_i,
  input  logic              hit_i,
  input  logic [MDP_W-1:0]  mdp_i,
  output logic [MDP_W-1:0]  new_o
);
  // A miss allocates a fresh entry, so every lane but the addressed one clears.
  assign new_o = (sel_i == LANE_W'(LANE_ID)) ? mdp_i : (hit_i ? old_i : '0);
endmodule

module mdpt_assoc #(
  parameter int N_LANES      = 8,
  parameter int N_SETS       = 64,
  parameter int N_WAYS       = 2,
  parameter int TAG_W        = 8,
  parameter int MDP_W        = 8,
  parameter int ASID_W       = 9,
  parameter int PC_W         = 38,
  parameter int DECAY_PERIOD = 4096,
  localparam int LANE_W      = $clog2(N_LANES),
  localparam int IDX_W       = $clog2(N_SETS)
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [ASID_W-1:0]          arch_asid,
  input  logic                       flush_valid,
  input  logic                       read_req_valid,
  input  logic [IDX_W+TAG_W-1:0]     read_req_block,
  output logic                       read_resp_valid,
  output logic                       read_resp_hit,
  output logic [N_LANES*MDP_W-1:0]   read_resp_mdp_by_lane,
  input  logic                       update_valid,
  input  logic [PC_W-1:0]            update_pc,
  input  logic [MDP_W-1:0]           update_mdp
);
  localparam int WAY_W = $clog2(N_WAYS);
  typedef logic [N_LANES-1:0][MDP_W-1:0] line_t;

  logic [N_SETS-1:0][N_WAYS-1:0] valid_q;
  logic [N_SETS-1:0][N_WAYS-2:0] plru_q;
  logic [TAG_W-1:0]              tag_q  [N_SETS][N_WAYS];
  line_t                         data_q [N_SETS][N_WAYS];

  logic       rsp_vld_q, rsp_hit_q;
  line_t      rsp_mdp_q;
  logic       decay_fire;

  logic [TAG_W-1:0] asid_tag;
  if (ASID_W >= TAG_W) begin : g_asid_trunc
    assign asid_tag = arch_asid[TAG_W-1:0];
  end else begin : g_asid_ext
    assign asid_tag = {{(TAG_W-ASID_W){1'b0}}, arch_asid};
  end

  if (PC_W > LANE_W+IDX_W+TAG_W || ASID_W > TAG_W) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^{update_pc, arch_asid};
  end

  // Read lookup
  logic [IDX_W-1:0] rd_set;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  line_t            rd_data;
  assign rd_set = read_req_block[IDX_W-1:0];
  assign rd_tag = read_req_block[IDX_W +: TAG_W] ^ asid_tag;

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    for (int w = 0; w < N_WAYS; w++)
      if (valid_q[rd_set][w] && tag_q[rd_set][w] == rd_tag) begin
        rd_hit  = 1'b1;
        rd_data = data_q[rd_set][w];
      end
  end

  // Update lookup and way selection
  logic [LANE_W-1:0] up_lane;
  logic [IDX_W-1:0]  up_set;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit, inv_any, up_commit;
  logic [WAY_W-1:0]  up_hit_way, inv_way, vict_way, up_way;
  logic [N_WAYS-1:0] vict_oh;
  logic [N_WAYS-2:0] plru_cur, plru_new;
  line_t             up_old, up_new;

  assign up_lane   = update_pc[LANE_W-1:0];
  assign up_set    = update_pc[LANE_W +: IDX_W];
  assign up_tag    = update_pc[LANE_W+IDX_W +: TAG_W] ^ asid_tag;
  assign plru_cur  = plru_q[up_set];
  assign up_commit = update_valid && !flush_valid && !decay_fire;

  // PLRU bits are heap-ordered nodes; each bit points toward the victim subtree (1 = right).
  for (genvar gv = 0; gv < N_WAYS; gv++) begin : g_vic
    logic [WAY_W-1:0] m;
    for (genvar gl = 0; gl < WAY_W; gl++) begin : g_lvl
      localparam int   NODE = (1 << gl) - 1 + (gv >> (WAY_W - gl));
      localparam logic DIR  = 1'((gv >> (WAY_W - 1 - gl)) & 1);
      assign m[gl] = (plru_cur[NODE] == DIR);
    end
    assign vict_oh[gv] = &m;
  end

  for (genvar gn = 0; gn < N_WAYS-1; gn++) begin : g_touch
    localparam int LVL = $clog2(gn + 2) - 1;
    localparam int POS = gn + 1 - (1 << LVL);
    assign plru_new[gn] = ((up_way >> (WAY_W - LVL)) == WAY_W'(POS)) ?
                          ~up_way[WAY_W-1-LVL] : plru_cur[gn];
  end

  always_comb begin
    up_hit     = 1'b0;
    up_hit_way = '0;
    inv_any    = 1'b0;
    inv_way    = '0;
    vict_way   = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      if (valid_q[up_set][w] && tag_q[up_set][w] == up_tag) begin
        up_hit     = 1'b1;
        up_hit_way = WAY_W'(w);
      end
      if (vict_oh[w]) vict_way = WAY_W'(w);
    end
    for (int w = N_WAYS-1; w >= 0; w--)
      if (!valid_q[up_set][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    up_way = up_hit ? up_hit_way : (inv_any ? inv_way : vict_way);
  end

  assign up_old = data_q[up_set][up_hit_way];

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    mdpt_assoc_lane #(.MDP_W(MDP_W), .LANE_W(LANE_W), .LANE_ID(gi)) u_lane (
      .old_i (up_old[gi]),
      .sel_i (up_lane),
      .hit_i (up_hit),
      .mdp_i (update_mdp),
      .new_o (up_new[gi])
    );
  end

  // Decay counter
  if (DECAY_PERIOD > 0) begin : g_decay
    localparam int CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    logic [CW-1:0] cnt_q;
    assign decay_fire = (cnt_q == CW'(DECAY_PERIOD - 1));
    always_ff @(posedge CLK or negedge nRST)
      if (!nRST)                          cnt_q <= '0;
      else if (flush_valid || decay_fire) cnt_q <= '0;
      else                                cnt_q <= cnt_q + 1'b1;
  end else begin : g_no_decay
    assign decay_fire = 1'b0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q   <= '0;
      plru_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_mdp_q <= '0;
    end else begin
      rsp_vld_q <= read_req_valid;
      rsp_hit_q <= read_req_valid && rd_hit;
      if (read_req_valid) rsp_mdp_q <= rd_hit ? rd_data : '0;
      if (flush_valid || decay_fire) valid_q <= '0;
      else if (up_commit) begin
        valid_q[up_set][up_way] <= 1'b1;
        plru_q[up_set]          <= plru_new;
      end
    end
  end

  always_ff @(posedge CLK)
    if (up_commit) begin
      tag_q[up_set][up_way]  <= up_tag;
      data_q[up_set][up_way] <= up_new;
    end

  assign read_resp_valid       = rsp_vld_q;
  assign read_resp_hit         = rsp_hit_q;
  assign read_resp_mdp_by_lane = rsp_mdp_q;
endmodule

// File: tb/tb_mdpt_assoc.sv
// Directed bench for mdpt_assoc at default parameters.
module tb_mdpt_assoc;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [8:0]  arch_asid;
  logic        flush_valid;
  logic        read_req_valid;
  logic [13:0] read_req_block;
  logic        read_resp_valid;
  logic        read_resp_hit;
  logic [63:0] read_resp_mdp_by_lane;
  logic        update_valid;
  logic [37:0] update_pc;
  logic [7:0]  update_mdp;

  int total = 0;
  int bad   = 0;

  mdpt_assoc dut (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .arch_asid             (arch_asid),
    .flush_valid           (flush_valid),
    .read_req_valid        (read_req_valid),
    .read_req_block        (read_req_block),
    .read_resp_valid       (read_resp_valid),
    .read_resp_hit         (read_resp_hit),
    .read_resp_mdp_by_lane (read_resp_mdp_by_lane),
    .update_valid          (update_valid),
    .update_pc             (update_pc),
    .update_mdp            (update_mdp)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_upd(input logic [5:0] s, input logic [7:0] t, input logic [2:0] l,
                         input logic [7:0] m);
    update_valid = 1'b1;
    update_pc    = {21'd0, t, s, l};
    update_mdp   = m;
  endtask

  task automatic set_rd(input logic [5:0] s, input logic [7:0] t);
    read_req_valid = 1'b1;
    read_req_block = {t, s};
  endtask

  task automatic upd(input logic [5:0] s, input logic [7:0] t, input logic [2:0] l,
                     input logic [7:0] m);
    set_upd(s, t, l, m);
    tick();
    update_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] s, input logic [7:0] t,
                    input logic exp_hit, input logic [63:0] exp_mdp);
    set_rd(s, t);
    tick();
    read_req_valid = 1'b0;
    chk({tag, ".vld"}, 64'(read_resp_valid), 64'd1);
    chk({tag, ".hit"}, 64'(read_resp_hit), 64'(exp_hit));
    chk({tag, ".mdp"}, read_resp_mdp_by_lane, exp_mdp);
  endtask

  task automatic flush;
    flush_valid = 1'b1;
    tick();
    flush_valid = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; arch_asid = '0; flush_valid = 1'b0;
    read_req_valid = 1'b0; read_req_block = '0;
    update_valid = 1'b0; update_pc = '0; update_mdp = '0;
    tick(); tick();
    chk("rst.vld", 64'(read_resp_valid), 64'd0);
    chk("rst.hit", 64'(read_resp_hit), 64'd0);
    chk("rst.mdp", read_resp_mdp_by_lane, 64'd0);
    nRST = 1'b1;
    tick();

    // 1: cold miss
    rd("t1", 6'd5, 8'h3C, 1'b0, 64'd0);

    // 2: allocate, read back, overwrite lane
    upd(6'd5, 8'h3C, 3'd2, 8'h81);
    rd("t2a", 6'd5, 8'h3C, 1'b1, 64'h0000_0000_0081_0000);
    tick();
    chk("idle.vld", 64'(read_resp_valid), 64'd0);
    chk("idle.hit", 64'(read_resp_hit), 64'd0);
    chk("idle.hold", read_resp_mdp_by_lane, 64'h0000_0000_0081_0000);
    upd(6'd5, 8'h3C, 3'd2, 8'h07);
    rd("t2b", 6'd5, 8'h3C, 1'b1, 64'h0000_0000_0007_0000);

    // 5: ASID isolation; bit 8 of the ASID falls outside the tag width
    arch_asid = 9'd1;
    rd("t5a", 6'd5, 8'h3C, 1'b0, 64'd0);
    arch_asid = 9'h100;
    rd("t5b", 6'd5, 8'h3C, 1'b1, 64'h0000_0000_0007_0000);
    arch_asid = 9'd0;
    rd("t5c", 6'd5, 8'h3C, 1'b1, 64'h0000_0000_0007_0000);

    // 3: PLRU eviction in set 5
    flush();
    rd("t3f", 6'd5, 8'h3C, 1'b0, 64'd0);
    upd(6'd5, 8'h10, 3'd0, 8'h11);
    upd(6'd5, 8'h20, 3'd1, 8'h22);
    upd(6'd5, 8'h10, 3'd3, 8'h33);
    upd(6'd5, 8'h30, 3'd0, 8'h44);
    rd("t3A", 6'd5, 8'h10, 1'b1, 64'h0000_0000_3300_0011);
    rd("t3B", 6'd5, 8'h20, 1'b0, 64'd0);
    rd("t3C", 6'd5, 8'h30, 1'b1, 64'h0000_0000_0000_0044);

    // 4: read-before-write in the same cycle
    set_upd(6'd9, 8'h55, 3'd7, 8'hA5);
    set_rd(6'd9, 8'h55);
    tick();
    update_valid = 1'b0; read_req_valid = 1'b0;
    chk("t4a.vld", 64'(read_resp_valid), 64'd1);
    chk("t4a.hit", 64'(read_resp_hit), 64'd0);
    chk("t4a.mdp", read_resp_mdp_by_lane, 64'd0);
    rd("t4b", 6'd9, 8'h55, 1'b1, 64'hA500_0000_0000_0000);

    // 6a: flush beats a same-cycle update
    flush_valid = 1'b1;
    set_upd(6'd12, 8'h01, 3'd1, 8'h5A);
    tick();
    flush_valid = 1'b0; update_valid = 1'b0;
    rd("t6fl", 6'd12, 8'h01, 1'b0, 64'd0);
    rd("t6fl2", 6'd9, 8'h55, 1'b0, 64'd0);

    // 6b: decay boundary; counter is 0 in the cycle after the flush edge
    flush();
    upd(6'd3, 8'h77, 3'd4, 8'hC3);
    repeat (4094) tick();
    rd("t6pre", 6'd3, 8'h77, 1'b1, 64'h0000_00C3_0000_0000);
    rd("t6post", 6'd3, 8'h77, 1'b0, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdpt_assoc.md
# mdpt_assoc

Parametrised, set-associative memory dependence prediction table (MDPT). It is the successor to the direct-mapped MDPT and sits beside the fetch front-end. A fetch-block read returns one MDP per instruction lane, one cycle later, with an explicit hit flag. Commit-side updates write single-lane MDPs into the table. New behaviour over the previous table:
- tagged ways with tree-PLRU replacement
- ASID-tagged entries
- periodic decay (flash invalidate) and an explicit flush

## Interface
Parameters:
- N_LANES, 8: MDP lanes per fetch block (power of 2); LANE_W = log2(N_LANES)
- N_SETS, 64: sets (power of 2); IDX_W = log2(N_SETS)
- N_WAYS, 2: ways per set (power of 2, ≥2)
- TAG_W, 8: stored tag bits
- MDP_W, 8: bits per MDP
- ASID_W, 9: ASID width (≥ TAG_W is not required; ASID is zero-extended or truncated to TAG_W)
- PC_W, 38: update PC width (must be ≥ LANE_W+IDX_W+TAG_W)
- DECAY_PERIOD, 4096: cycles between flash invalidates; 0 disables decay

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- arch_asid  in  ASID_W  current address-space ID
- flush_valid  in  1  invalidate all entries, restart decay counter
- read_req_valid  in  1  fetch-block lookup request
- read_req_block  in  IDX_W+TAG_W  fetch-block address; [IDX_W-1:0] is the set, upper bits are the raw tag
- read_resp_valid  out  1  response valid
- read_resp_hit  out  1  tag hit
- read_resp_mdp_by_lane  out  N_LANES*MDP_W  per-lane MDPs; lane i is at [i*MDP_W +: MDP_W]
- update_valid  in  1  update request
- update_pc  in  PC_W  PC of the instruction; lane = [LANE_W-1:0], set = [LANE_W +: IDX_W], raw tag = [LANE_W+IDX_W +: TAG_W]
- update_mdp  in  MDP_W  new MDP value

## Operation
Entry contents: valid, tag, N_LANES×MDP_W data. Each set also holds N_WAYS-1 PLRU bits.

Effective tag = raw tag XOR arch_asid, with arch_asid truncated or zero-extended to TAG_W. Lookups and writes both use the effective tag, so changing the ASID implicitly misses the old context's entries.

Read:
- Compare the effective tag against every valid way of the set.
- On a hit, return that way's data.
- On a miss, return all-zero data and read_resp_hit=0.
- At most one way can match.
- Reads do not touch the PLRU bits.

Update, on a hit:
- Write update_mdp into the hit way's lane. Other lanes are unchanged.
- Point the PLRU away from the hit way.

Update, on a miss:
- Victim selection: the lowest-index invalid way if one exists, otherwise the PLRU victim.
- Write valid=1 and the tag.
- Clear all lanes to 0, then write update_mdp into the addressed lane.
- Point the PLRU away from the victim.

Decay:
- A free-running counter counts 0..DECAY_PERIOD-1.
- In the cycle where the count equals DECAY_PERIOD-1, all valid bits clear at the clock edge and the counter wraps to 0.
- PLRU bits and data are unchanged by decay.

Flush:
- Clears all valid bits and resets the decay counter to 0 at the clock edge.

Priority, within the same cycle:
- flush or decay beats update; the update is dropped.
- An update that coincides with nothing else commits normally.

## Timing
Reset values:
- All valid bits, PLRU bits, and the decay counter: 0.
- read_resp_valid=0, read_resp_hit=0, read_resp_mdp_by_lane=0.

Data storage does not need reset; it is never visible unless valid=1.

Read latency is 1 cycle:
- A request in cycle N produces registered outputs in cycle N+1.
- read_resp_valid(N+1) = read_req_valid(N).
- When read_resp_valid=0, read_resp_hit is 0 and read_resp_mdp_by_lane holds its last value.

Read-before-write:
- A read in cycle N sees array state from before any update, flush, or decay committing at the end of cycle N.
- Those effects are visible to reads from cycle N+1.

ASID: arch_asid is sampled in the same cycle as the read request or update it applies to.

Back-to-back reads and updates are accepted every cycle, with no stalls and no ready signal.

Reset mid-operation: everything returns to the reset values immediately, and any in-flight response is lost.

## Test plan
Defaults throughout; "set s / tag t / lane l" means the address fields.
1. Reset, then read set 5 / tag 0x3C → next cycle: read_resp_valid=1, hit=0, mdp=0.
2. asid=0. Update set 5 / tag 0x3C / lane 2 / mdp 0x81, then read set 5 / tag 0x3C → hit=1, lane2=0x81, all other lanes 0x00. Then update lane 2 with 0x07 → lane2=0x07.
3. In set 5, update tag A=0x10, then B=0x20, then A again, then C=0x30 → B is evicted: B misses, A and C hit.
4. Update and read of the same entry in the same cycle N (first write) → cycle N+1 response hit=0. Reading again → hit=1 with the new MDP.
5. Write at asid=0, switch arch_asid to 1, read → hit=0. Switch back to 0 → hit=1 with the data intact.
6. Decay: write an entry, then read it across the DECAY_PERIOD-1 boundary → hit before, miss after. Flush and update in the same cycle → the following read misses.
